// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM type, bus idle levels and flattened-field helper for bus_cycle_arbiter
package bus_arb_pkg;
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_ADDR    = 4'b0010,
    S_XFER    = 4'b0100,
    S_RECOVER = 4'b1000
  } bus_arb_state_t;
  localparam logic RD_IDLE = 1'b1;
  localparam logic WR_IDLE = 1'b1;
  // Widest flattened vector get_field accepts; fields are at most 32 bits wide.
  localparam int FIELD_VEC_W = 256;
  function automatic logic [31:0] get_field(input logic [FIELD_VEC_W-1:0] vec, input int i, input int w);
    logic [FIELD_VEC_W-1:0] s;
    logic [32:0] m;
    s = vec >> (i * w);
    m = (33'h1 << w) - 33'h1;
    return s[31:0] & m[31:0];
  endfunction
endpackage

// File: rtl/bus_cycle_arbiter_rr_pick.sv
// rr_pick: combinational requester picker; round-robin from ptr+1 under ROUND_ROBIN_EN, else lowest index wins
module rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
`ifdef ROUND_ROBIN_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
`ifdef ROUND_ROBIN_EN
  logic [IW-1:0] c;
  // Walk candidates farthest-first from ptr so the nearest pending one is written last and wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % N);
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        idx = c;
      end
    end
  end
`else
  // Plain priority encoder, highest index first so the lowest pending index wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int j = N - 1; j >= 0; j--)
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
  end
`endif
endmodule

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: shares one 8088-style bus slave among NUM_REQ requesters (ROUND_ROBIN_EN: round-robin, else fixed priority)
module bus_cycle_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ-1:0]             REQ_WE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_WDATA,
  output logic [NUM_REQ-1:0]             DONE,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [$clog2(NUM_REQ)-1:0]     GNT_ID,
  output logic                           ALE,
  output logic                           CS,
  output logic                           RD,
  output logic                           WR,
  output logic [ADDR_WIDTH-1:0]          ADDRESS,
  inout  wire  [DATA_WIDTH-1:0]          DATA
);
  localparam int IW = $clog2(NUM_REQ);
  bus_arb_state_t state;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic cap_we;
  logic [DATA_WIDTH-1:0] cap_wdata;
`ifdef ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
`endif
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (REQ),
`ifdef ROUND_ROBIN_EN
    .ptr (ptr),
`endif
    .gnt (pick_gnt),
    .idx (pick_idx)
  );
  // The arbiter only drives DATA during a write strobe; WR is registered so this is glitch-free.
  assign DATA = WR ? 'z : cap_wdata;
  // Bus sequencer: IDLE/RECOVER arbitrate and capture, ADDR latches, XFER strobes, RECOVER reports DONE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      ALE       <= 1'b0;
      CS        <= 1'b0;
      RD        <= RD_IDLE;
      WR        <= WR_IDLE;
      ADDRESS   <= '0;
      DONE      <= '0;
      RDATA     <= '0;
      GNT_ID    <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
`ifdef ROUND_ROBIN_EN
      ptr       <= IW'(NUM_REQ - 1);
`endif
    end else begin
      DONE <= '0;
      case (state)
        S_ADDR: begin
          state <= S_XFER;
          ALE   <= 1'b0;
          RD    <= cap_we;
          WR    <= ~cap_we;
        end
        S_XFER: begin
          state <= S_RECOVER;
          CS    <= 1'b0;
          RD    <= RD_IDLE;
          WR    <= WR_IDLE;
          DONE  <= NUM_REQ'(1) << GNT_ID;
          if (!cap_we) RDATA <= DATA;
        end
        default: begin
          if (|pick_gnt) begin
            state     <= S_ADDR;
            ALE       <= 1'b1;
            CS        <= 1'b1;
            GNT_ID    <= pick_idx;
            cap_we    <= REQ_WE[pick_idx];
            ADDRESS   <= ADDR_WIDTH'(get_field(FIELD_VEC_W'(REQ_ADDR), int'(pick_idx), ADDR_WIDTH));
            cap_wdata <= DATA_WIDTH'(get_field(FIELD_VEC_W'(REQ_WDATA), int'(pick_idx), DATA_WIDTH));
`ifdef ROUND_ROBIN_EN
            ptr       <= pick_idx;
`endif
          end else
            state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// tb_bus_cycle_arbiter: table-driven per-cycle vectors plus a latency sequence against a small bus slave model
module tb_bus_cycle_arbiter;
  localparam logic [3:0] BI  = 4'b0011;
  localparam logic [3:0] BA  = 4'b1111;
  localparam logic [3:0] BXR = 4'b0101;
  localparam logic [3:0] BXW = 4'b0110;
  localparam logic [18:0] A0 = 19'h00010;
  localparam logic [18:0] A1 = 19'h7FFFF;
`ifdef ROUND_ROBIN_EN
  localparam logic        G  = 1'b1;
  localparam logic [18:0] AG = A1;
  localparam logic [7:0]  DG = 8'h3C;
  localparam logic [1:0]  DN = 2'b10;
`else
  localparam logic        G  = 1'b0;
  localparam logic [18:0] AG = A0;
  localparam logic [7:0]  DG = 8'hA5;
  localparam logic [1:0]  DN = 2'b01;
`endif
  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  bus;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        gnt;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        dz;
  } vec_t;
  function automatic vec_t mkv(input logic rst, input logic [1:0] req, we, input logic [3:0] bus,
                               input logic [1:0] done, input logic [7:0] rdata, input logic gnt,
                               input logic [18:0] addr, input logic [7:0] data);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.bus = bus; v.done = done;
    v.rdata = rdata; v.gnt = gnt; v.addr = addr; v.data = data;
    v.dz = (bus != BXR) && (bus != BXW);
    return v;
  endfunction
  logic CLK = 1'b0;
  logic RESET;
  logic [1:0] REQ, REQ_WE, DONE;
  logic [37:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic [7:0] RDATA;
  logic GNT_ID, ALE, CS, RD, WR;
  logic [18:0] ADDRESS;
  wire [7:0] DATA;
  logic [7:0] mem [16];
  logic [18:0] lat;
  vec_t tv [30];
  logic [41:0] got, want;
  int n_vec = 0;
  int n_bad = 0;
  int cyc;
  always #5 CLK = ~CLK;
  bus_cycle_arbiter dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .DONE(DONE), .RDATA(RDATA), .GNT_ID(GNT_ID), .ALE(ALE),
    .CS(CS), .RD(RD), .WR(WR), .ADDRESS(ADDRESS), .DATA(DATA)
  );
  assign DATA = (CS && !RD) ? mem[lat[3:0]] : 'z;
  always @(posedge CLK) begin
    if (RESET) mem[0] <= 8'hA5;
    if (ALE) lat <= ADDRESS;
    if (CS && !WR) mem[lat[3:0]] <= DATA;
  end
  initial begin
    tv[0]  = mkv(1, 2'b00, 2'b00, BI,  2'b00, 8'h00, 0, 19'h0, 8'h00);
    tv[1]  = mkv(0, 2'b01, 2'b00, BA,  2'b00, 8'h00, 0, A0, 8'h00);
    tv[2]  = mkv(0, 2'b01, 2'b00, BXR, 2'b00, 8'h00, 0, A0, 8'hA5);
    tv[3]  = mkv(0, 2'b01, 2'b00, BI,  2'b01, 8'hA5, 0, A0, 8'h00);
    tv[4]  = mkv(0, 2'b00, 2'b00, BI,  2'b00, 8'hA5, 0, A0, 8'h00);
    tv[5]  = mkv(0, 2'b10, 2'b10, BA,  2'b00, 8'hA5, 1, A1, 8'h00);
    tv[6]  = mkv(0, 2'b10, 2'b10, BXW, 2'b00, 8'hA5, 1, A1, 8'h3C);
    tv[7]  = mkv(0, 2'b10, 2'b10, BI,  2'b10, 8'hA5, 1, A1, 8'h00);
    tv[8]  = mkv(0, 2'b10, 2'b00, BA,  2'b00, 8'hA5, 1, A1, 8'h00);
    tv[9]  = mkv(0, 2'b10, 2'b00, BXR, 2'b00, 8'hA5, 1, A1, 8'h3C);
    tv[10] = mkv(0, 2'b00, 2'b00, BI,  2'b10, 8'h3C, 1, A1, 8'h00);
    tv[11] = mkv(0, 2'b00, 2'b00, BI,  2'b00, 8'h3C, 1, A1, 8'h00);
    tv[12] = mkv(0, 2'b11, 2'b00, BA,  2'b00, 8'h3C, 0, A0, 8'h00);
    tv[13] = mkv(0, 2'b11, 2'b00, BXR, 2'b00, 8'h3C, 0, A0, 8'hA5);
    tv[14] = mkv(0, 2'b11, 2'b00, BI,  2'b01, 8'hA5, 0, A0, 8'h00);
    tv[15] = mkv(0, 2'b11, 2'b00, BA,  2'b00, 8'hA5, G, AG, 8'h00);
    tv[16] = mkv(0, 2'b11, 2'b00, BXR, 2'b00, 8'hA5, G, AG, DG);
    tv[17] = mkv(0, 2'b11, 2'b00, BI,  DN,    DG,    G, AG, 8'h00);
    tv[18] = mkv(0, 2'b11, 2'b00, BA,  2'b00, DG,    0, A0, 8'h00);
    tv[19] = mkv(0, 2'b01, 2'b00, BXR, 2'b00, DG,    0, A0, 8'hA5);
    tv[20] = mkv(0, 2'b10, 2'b00, BI,  2'b01, 8'hA5, 0, A0, 8'h00);
    tv[21] = mkv(0, 2'b00, 2'b00, BI,  2'b00, 8'hA5, 0, A0, 8'h00);
    tv[22] = mkv(0, 2'b00, 2'b00, BI,  2'b00, 8'hA5, 0, A0, 8'h00);
    tv[23] = mkv(0, 2'b01, 2'b00, BA,  2'b00, 8'hA5, 0, A0, 8'h00);
    tv[24] = mkv(0, 2'b01, 2'b00, BXR, 2'b00, 8'hA5, 0, A0, 8'hA5);
    tv[25] = mkv(1, 2'b01, 2'b00, BI,  2'b00, 8'h00, 0, 19'h0, 8'h00);
    tv[26] = mkv(0, 2'b01, 2'b00, BA,  2'b00, 8'h00, 0, A0, 8'h00);
    tv[27] = mkv(0, 2'b01, 2'b00, BXR, 2'b00, 8'h00, 0, A0, 8'hA5);
    tv[28] = mkv(0, 2'b01, 2'b00, BI,  2'b01, 8'hA5, 0, A0, 8'h00);
    tv[29] = mkv(0, 2'b00, 2'b00, BI,  2'b00, 8'hA5, 0, A0, 8'h00);
    REQ_ADDR = {A1, A0};
    REQ_WDATA = {8'h3C, 8'h00};
    RESET = 1'b1;
    REQ = 2'b00;
    REQ_WE = 2'b00;
    @(negedge CLK);
    for (int i = 0; i < 30; i++) begin
      RESET = tv[i].rst;
      REQ = tv[i].req;
      REQ_WE = tv[i].we;
      @(posedge CLK);
      @(negedge CLK);
      got  = {ALE, CS, RD, WR, DONE, RDATA, GNT_ID, ADDRESS, tv[i].dz ? 8'h00 : DATA};
      want = {tv[i].bus, tv[i].done, tv[i].rdata, tv[i].gnt, tv[i].addr, tv[i].dz ? 8'h00 : tv[i].data};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL vec%0d: got ale/cs/rd/wr=%b done=%b rdata=%h gnt=%0d addr=%h data=%h, want %b done=%b rdata=%h gnt=%0d addr=%h data=%h",
                 i, {ALE, CS, RD, WR}, DONE, RDATA, GNT_ID, ADDRESS, DATA,
                 tv[i].bus, tv[i].done, tv[i].rdata, tv[i].gnt, tv[i].addr, tv[i].data);
      end
    end
    REQ = 2'b10;
    REQ_WE = 2'b00;
    cyc = 0;
    do begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
    end while (DONE[1] !== 1'b1 && cyc < 10);
    n_vec++;
    if (cyc != 3) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles to DONE[1], want 3", cyc);
    end
    n_vec++;
    if (RDATA !== 8'h3C) begin
      n_bad++;
      $display("FAIL latency_rdata: got %h, want 3c", RDATA);
    end
    REQ = 2'b00;
    @(posedge CLK);
    @(negedge CLK);
    n_vec++;
    if ({ALE, CS, RD, WR, DONE} !== {BI, 2'b00}) begin
      n_bad++;
      $display("FAIL back_to_idle: got %b, want %b", {ALE, CS, RD, WR, DONE}, {BI, 2'b00});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
